// File: rtl/psk_pkg.sv
// Shared types and default constants for the PSK encoder slice.
// The optional preamble is enabled by defining PSK_ENCODER_PREAMBLE_EN.
package psk_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } psk_state_e;

  localparam int BIT_CYCLES_DEF    = 4096;
  localparam int CARRIER_HALF_DEF  = 256;
  localparam int PREAMBLE_BITS_DEF = 8;

endpackage

// File: rtl/psk_carrier_gen.sv
// Square-wave carrier: toggles every CARRIER_HALF enabled cycles, restarts low on clr.
module psk_carrier_gen #(
  parameter int CARRIER_HALF = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic carrier
);

  localparam int CW = $clog2(CARRIER_HALF + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CARRIER_HALF - 1);

  logic [CW-1:0] half_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      half_cnt <= '0;
      carrier  <= 1'b0;
    end else if (en) begin
      if (half_cnt == HALF_LAST) begin
        half_cnt <= '0;
        carrier  <= ~carrier;
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/psk_encoder.sv
// Differential PSK encoder: serialises bytes LSB first onto a square carrier.
// Define PSK_ENCODER_PREAMBLE_EN to prefix each frame with alternating preamble bits.
module psk_encoder
  import psk_pkg::*;
#(
  parameter int BIT_CYCLES    = BIT_CYCLES_DEF,
  parameter int CARRIER_HALF  = CARRIER_HALF_DEF,
  parameter int PREAMBLE_BITS = PREAMBLE_BITS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       psk_signal,
  output logic       busy,
  output logic       bit_strobe
);

  if (BIT_CYCLES < 4 || CARRIER_HALF < 1 || (BIT_CYCLES % (2 * CARRIER_HALF)) != 0) begin : g_bad_timing
    $error("psk_encoder: BIT_CYCLES must be >= 4 and a multiple of 2*CARRIER_HALF");
  end
  if (PREAMBLE_BITS < 1 || PREAMBLE_BITS > 255) begin : g_bad_preamble
    $error("psk_encoder: PREAMBLE_BITS must be in 1..255");
  end

  localparam int BW = $clog2(BIT_CYCLES);
  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYCLES - 1);

  // Handshake: a byte is accepted on any cycle where tx_valid && tx_ready; tx_valid
  // may drop or tx_data change freely before that with no effect.
  psk_state_e state;
  logic [BW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          phase;
  logic          carrier;
  logic          bit_last;
  logic          accept;
  logic          frame_start;

`ifdef PSK_ENCODER_PREAMBLE_EN
  localparam int PW = $clog2(PREAMBLE_BITS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_BITS - 1);
  logic [PW-1:0] pre_cnt;
`endif

  assign bit_last    = (bit_cnt == BIT_LAST);
  assign busy        = (state != IDLE);
  assign tx_ready    = !rst && ((state == IDLE) ||
                                ((state == DATA) && bit_last && (bit_idx == 3'd7)));
  assign accept      = tx_valid && tx_ready;
  assign frame_start = accept && (state == IDLE);
  assign bit_strobe  = busy && (bit_cnt == '0);
  assign psk_signal  = busy && (carrier ^ phase);

  psk_carrier_gen #(
    .CARRIER_HALF(CARRIER_HALF)
  ) u_carrier (
    .clk    (clk),
    .rst    (rst),
    .clr    (frame_start),
    .en     (busy),
    .carrier(carrier)
  );

  // phase is pre-loaded with the value of the bit about to start, so the
  // inversion is visible on that bit's first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      phase   <= 1'b0;
`ifdef PSK_ENCODER_PREAMBLE_EN
      pre_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= tx_data;
            bit_cnt <= '0;
            bit_idx <= '0;
`ifdef PSK_ENCODER_PREAMBLE_EN
            state   <= PREAMBLE;
            pre_cnt <= '0;
            phase   <= 1'b1;
`else
            state   <= DATA;
            phase   <= tx_data[0];
`endif
          end
        end
`ifdef PSK_ENCODER_PREAMBLE_EN
        PREAMBLE: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (pre_cnt == PRE_LAST) begin
              state <= DATA;
              phase <= phase ^ shreg[0];
            end else begin
              pre_cnt <= pre_cnt + 1'b1;
              // next preamble bit is 1 exactly when the current index is odd
              phase   <= phase ^ pre_cnt[0];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`endif
        DATA: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              if (accept) begin
                shreg   <= tx_data;
                bit_idx <= '0;
                phase   <= phase ^ tx_data[0];
              end else begin
                state <= IDLE;
                shreg <= '0;
                phase <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              phase   <= phase ^ shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psk_encoder.sv
// Self-checking bench for psk_encoder; expected waveforms come from a per-bit model.
module tb_psk_encoder;

  localparam int BC = 16;
  localparam int CH = 4;
  localparam int PB = 2;
`ifdef PSK_ENCODER_PREAMBLE_EN
  localparam int PRE = PB;
`else
  localparam int PRE = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       psk_signal;
  logic       busy;
  logic       bit_strobe;

  int checks   = 0;
  int failures = 0;

  // expected per cycle: {psk_signal, busy, bit_strobe, tx_ready}
  logic [3:0] exp_q[$];
  logic [7:0] tx_bytes[$];

  psk_encoder #(
    .BIT_CYCLES   (BC),
    .CARRIER_HALF (CH),
    .PREAMBLE_BITS(PB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .psk_signal(psk_signal),
    .busy      (busy),
    .bit_strobe(bit_strobe)
  );

  always #5 clk = ~clk;

  // Reference: list of transmitted bits, phase = running parity of those bits,
  // carrier = (cycles since frame start / CH) mod 2.
  task automatic build_expected();
    int bits[$];
    int ph;
    int n;
    logic [7:0] b;
    exp_q.delete();
    for (int k = 0; k < PRE; k++) bits.push_back((k % 2 == 0) ? 1 : 0);
    for (int q = 0; q < tx_bytes.size(); q++) begin
      b = tx_bytes[q];
      for (int i = 0; i < 8; i++) bits.push_back(int'(b[i]));
    end
    ph = 0;
    for (int bi = 0; bi < bits.size(); bi++) begin
      ph = ph ^ bits[bi];
      for (int j = 0; j < BC; j++) begin
        n = bi * BC + j;
        exp_q.push_back({1'(((n / CH) % 2) ^ ph), 1'b1, 1'(j == 0),
                         1'((bi >= PRE) && (((bi - PRE) % 8) == 7) && (j == BC - 1))});
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!(tx_ready === 1'b1 && busy === 1'b0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      checks++;
      failures++;
      $display("FAIL %s idle_timeout got busy=%b ready=%b want busy=0 ready=1", name, busy, tx_ready);
    end
  endtask

  // Sends tx_bytes as one frame; random tx_valid/tx_data noise on non-ready cycles.
  task automatic run_frame(input string name, input int stop_at);
    logic [3:0] e;
    logic [3:0] got;
    int idx;
    int len;
    build_expected();
    len = exp_q.size();
    wait_idle(name);
    tx_valid = 1'b1;
    tx_data  = tx_bytes[0];
    idx      = 1;
    @(posedge clk);
    for (int c = 0; c < len && c < stop_at; c++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      got = {psk_signal, busy, bit_strobe, tx_ready};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s cycle=%0d got {psk,busy,strobe,ready}=%b want %b", name, c, got, e);
      end
      if (e[0] && idx < tx_bytes.size()) begin
        tx_valid = 1'b1;
        tx_data  = tx_bytes[idx];
        idx++;
      end else if (e[0] || c == stop_at - 1) begin
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
      end else begin
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom);
      end
    end
    if (stop_at >= len) begin
      @(negedge clk);
      got = {psk_signal, busy, bit_strobe, tx_ready};
      checks++;
      if (got !== 4'b0001) begin
        failures++;
        $display("FAIL %s after_frame got {psk,busy,strobe,ready}=%b want 0001", name, got);
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] got;
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'($urandom);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || psk_signal !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold got busy=%b psk=%b want 0 0", busy, psk_signal);
      end
    end
    rst      = 1'b0;
    tx_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      got = {psk_signal, busy, bit_strobe, tx_ready};
      checks++;
      if (got !== 4'b0001) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d got {psk,busy,strobe,ready}=%b want 0001", i, got);
      end
    end
  endtask

  task automatic test_single(input string name, input logic [7:0] b);
    tx_bytes.delete();
    tx_bytes.push_back(b);
    run_frame(name, 1 << 20);
  endtask

  task automatic test_back_to_back();
    tx_bytes.delete();
    tx_bytes.push_back(8'hA5);
    tx_bytes.push_back(8'h3C);
    run_frame("b2b_a5_3c", 1 << 20);
    tx_bytes.delete();
    for (int i = 0; i < 3; i++) tx_bytes.push_back(8'($urandom));
    run_frame("b2b_random", 1 << 20);
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) test_single("random_byte", 8'($urandom));
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] got;
    tx_bytes.delete();
    tx_bytes.push_back(8'($urandom_range(1, 255)));
    run_frame("pre_abort", 40);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || psk_signal !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_rst got busy=%b psk=%b want 0 0", busy, psk_signal);
    end
    rst = 1'b0;
    @(negedge clk);
    got = {psk_signal, busy, bit_strobe, tx_ready};
    checks++;
    if (got !== 4'b0001) begin
      failures++;
      $display("FAIL abort_idle got {psk,busy,strobe,ready}=%b want 0001", got);
    end
    test_single("after_abort", 8'($urandom));
  endtask

  initial begin
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    test_reset();
    test_single("byte_00", 8'h00);
    test_single("byte_01", 8'h01);
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
